// File: rtl/sha_mem_pkg.sv
// rtl/sha_mem_pkg.sv - shared defaults and types for the SHA core memory arbiter
// Purpose: default SRAM geometry, requester count and the requester id type.
// Ports: none (package).
package sha_mem_pkg;

    localparam int SHA_NUM_REQ   = 4;
    localparam int SHA_ADDR_W    = 16;
    localparam int SHA_DATA_W    = 32;
    localparam int SHA_MAX_BURST = 16;

    typedef logic [$clog2(SHA_NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Purpose: choose the first set request scanning upward from prio_ptr with wrap-around.
// Ports:
//   req      in  NUM_REQ  request vector
//   prio_ptr in  ID_W     index holding highest priority
//   pick     out NUM_REQ  one-hot winner (zero when nothing requests)
//   found    out 1        some request was set
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    prio_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               found
);

    // Two passes: indices at/above the pointer first, then the wrapped lower ones.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (ID_W'(i) >= prio_ptr)) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (ID_W'(i) < prio_ptr)) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha_mem_arbiter.sv
// rtl/sha_mem_arbiter.sv - round-robin burst arbiter sharing one SRAM port among SHA cores
// Purpose: mux NUM_REQ core memory ports onto a single-port SRAM with bounded bursts
//          and route registered read returns back to the issuing core.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   req/we/addr/wdata     per-core request, write enable, word address, write data
//   gnt                   one-hot combinational grant
//   rd_valid/rd_data      one-hot read return strobe, broadcast read data
//   mem_we/mem_addr/mem_write_data/mem_read_data   SRAM port
module sha_mem_arbiter import sha_mem_pkg::*; #(
    parameter int NUM_REQ   = SHA_NUM_REQ,
    parameter int ADDR_W    = SHA_ADDR_W,
    parameter int DATA_W    = SHA_DATA_W,
    parameter int MAX_BURST = SHA_MAX_BURST
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_write_data,
    input  logic [DATA_W-1:0]         mem_read_data
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    logic [ID_W-1:0]  owner_q, owner_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [ID_W-1:0]  prio_ptr_q, prio_ptr_d;
    logic             rd_pend_q, rd_pend_d;
    logic [ID_W-1:0]  rd_id_q, rd_id_d;

    logic               keep;
    logic               drop;
    logic [ID_W-1:0]    ptr_eff;
    logic [NUM_REQ-1:0] pick;
    logic               found;
    logic [NUM_REQ-1:0] gnt_c;
    logic [ID_W-1:0]    gnt_id;
    logic               acc;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] x);
        return (x == ID_W'(NUM_REQ - 1)) ? '0 : x + ID_W'(1);
    endfunction

    assign keep = busy_q && req[owner_q] && (burst_cnt_q < CNT_LAST);
    assign drop = busy_q && !req[owner_q];
    // A dropping owner hands priority onward in the same cycle so the switch costs no dead cycle.
    assign ptr_eff = drop ? next_id(owner_q) : prio_ptr_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req      (req),
        .prio_ptr (ptr_eff),
        .pick     (pick),
        .found    (found)
    );

    always_comb begin
        gnt_c          = '0;
        gnt_id         = '0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (!reset) begin
            if (keep) begin
                gnt_c[owner_q] = 1'b1;
            end else if (found) begin
                gnt_c = pick;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) begin
                gnt_id         = ID_W'(i);
                mem_we         = we[i];
                mem_addr       = addr[i*ADDR_W +: ADDR_W];
                mem_write_data = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign gnt = gnt_c;
    // A grant is only ever given to an active requester, so any grant is an accepted access.
    assign acc = |gnt_c;

    always_comb begin
        owner_d     = owner_q;
        busy_d      = busy_q;
        burst_cnt_d = burst_cnt_q;
        prio_ptr_d  = prio_ptr_q;
        rd_pend_d   = 1'b0;
        rd_id_d     = rd_id_q;
        if (drop) begin
            busy_d     = 1'b0;
            prio_ptr_d = next_id(owner_q);
        end
        if (acc) begin
            owner_d = gnt_id;
            busy_d  = 1'b1;
            if (gnt_id == owner_q && busy_q && burst_cnt_q < CNT_LAST) begin
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end else begin
                burst_cnt_d = '0;
            end
            // Burst limit reached: owner drops to lowest priority for the next pick.
            if (burst_cnt_d == CNT_LAST) begin
                prio_ptr_d = next_id(gnt_id);
            end
            rd_pend_d = !mem_we;
            rd_id_d   = gnt_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q     <= '0;
            busy_q      <= 1'b0;
            burst_cnt_q <= '0;
            prio_ptr_q  <= '0;
            rd_pend_q   <= 1'b0;
            rd_id_q     <= '0;
        end else begin
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            burst_cnt_q <= burst_cnt_d;
            prio_ptr_q  <= prio_ptr_d;
            rd_pend_q   <= rd_pend_d;
            rd_id_q     <= rd_id_d;
        end
    end

    assign rd_valid = rd_pend_q ? (NUM_REQ'(1) << rd_id_q) : '0;
    assign rd_data  = mem_read_data;

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// tb/tb_sha_mem_arbiter.sv - directed self-checking bench for sha_mem_arbiter
module tb_sha_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    we = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rd_valid;
    logic [DW-1:0]   rd_data;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_write_data;
    logic [DW-1:0]   mem_read_data = '0;

    logic [DW-1:0]   sram [0:65535];
    int              wr_count = 0;
    int              n_checks = 0;
    int              n_fail = 0;

    sha_mem_arbiter #(
        .NUM_REQ   (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .we             (we),
        .addr           (addr),
        .wdata          (wdata),
        .gnt            (gnt),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            sram[mem_addr] <= mem_write_data;
            wr_count       <= wr_count + 1;
        end
        mem_read_data <= sram[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int i, input logic r, input logic w,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]            = r;
        we[i]             = w;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    logic [N-1:0]  exp_g;
    logic [N-1:0]  prev_g;
    logic [AW-1:0] exp_a;
    logic [N-1:0]  t4_req [0:6];
    logic [N-1:0]  t4_gnt [0:6];
    int            w0;

    initial begin
        // Reset: outputs quiescent even with all cores requesting writes.
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b1, AW'(16'h0040 + i), DW'(32'hA0 + i));
        #2;
        check("rst_gnt", gnt, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_write_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        do_reset();

        // Single core 1: write then read, switching we inside one tenure.
        set_core(1, 1'b1, 1'b1, 16'd1000, 32'hDEADBEEF);
        #2;
        check("t1_gnt_wr", gnt, 4'b0010);
        check("t1_mem_we_wr", mem_we, 1);
        check("t1_mem_addr_wr", mem_addr, 1000);
        check("t1_mem_wdata", mem_write_data, 32'hDEADBEEF);
        cyc();
        set_core(1, 1'b1, 1'b0, 16'd1000, 32'h0);
        #2;
        check("t1_gnt_rd", gnt, 4'b0010);
        check("t1_mem_we_rd", mem_we, 0);
        check("t1_no_rdv_after_wr", rd_valid, 0);
        cyc();
        set_core(1, 1'b0, 1'b0, 16'd0, 32'h0);
        #2;
        check("t1_rd_valid", rd_valid, 4'b0010);
        check("t1_rd_data", rd_data, 32'hDEADBEEF);
        check("t1_gnt_idle", gnt, 0);
        cyc();
        #2;
        check("t1_rd_valid_clear", rd_valid, 0);

        // Cores 0 and 2 streaming reads: tenures of MB alternate with no gap.
        do_reset();
        set_core(0, 1'b1, 1'b0, 16'h0100, 32'h0);
        set_core(2, 1'b1, 1'b0, 16'h0102, 32'h0);
        prev_g = '0;
        for (int c = 0; c < 3 * MB; c++) begin
            exp_g = (((c / MB) % 2) == 0) ? 4'b0001 : 4'b0100;
            exp_a = (((c / MB) % 2) == 0) ? 16'h0100 : 16'h0102;
            #2;
            check($sformatf("t2_gnt_c%0d", c), gnt, exp_g);
            check($sformatf("t2_addr_c%0d", c), mem_addr, exp_a);
            check($sformatf("t2_rdv_c%0d", c), rd_valid, prev_g);
            prev_g = exp_g;
            cyc();
        end

        // All four cores from reset: tenure order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < N; i++) set_core(i, 1'b1, 1'b0, AW'(16'h0200 + i), 32'h0);
        prev_g = '0;
        for (int c = 0; c < 5 * MB; c++) begin
            exp_g = N'(1) << ((c / MB) % N);
            #2;
            check($sformatf("t3_gnt_c%0d", c), gnt, exp_g);
            check($sformatf("t3_rdv_c%0d", c), rd_valid, prev_g);
            prev_g = exp_g;
            cyc();
        end

        // Core 3 drops after two reads while core 1 waits.
        t4_req[0] = 4'b1000; t4_gnt[0] = 4'b1000;
        t4_req[1] = 4'b1010; t4_gnt[1] = 4'b1000;
        t4_req[2] = 4'b0010; t4_gnt[2] = 4'b0010;
        t4_req[3] = 4'b0011; t4_gnt[3] = 4'b0010;
        t4_req[4] = 4'b0011; t4_gnt[4] = 4'b0010;
        t4_req[5] = 4'b0011; t4_gnt[5] = 4'b0010;
        t4_req[6] = 4'b0011; t4_gnt[6] = 4'b0001;
        do_reset();
        prev_g = '0;
        for (int c = 0; c < 7; c++) begin
            req = t4_req[c];
            we  = '0;
            #2;
            check($sformatf("t4_gnt_c%0d", c), gnt, t4_gnt[c]);
            check($sformatf("t4_rdv_c%0d", c), rd_valid, prev_g);
            prev_g = t4_gnt[c];
            cyc();
        end

        // Reset mid-tenure with a read pending and a write on the port.
        do_reset();
        set_core(0, 1'b1, 1'b0, 16'd5, 32'h0);
        #2;
        check("t5_gnt_pre", gnt, 4'b0001);
        cyc();
        set_core(0, 1'b1, 1'b1, 16'd5, 32'h12345678);
        #2;
        check("t5_rdv_pre", rd_valid, 4'b0001);
        check("t5_mem_we_pre", mem_we, 1);
        reset = 1'b1;
        #1;
        check("t5_gnt_rst", gnt, 0);
        check("t5_mem_we_rst", mem_we, 0);
        check("t5_rdv_rst", rd_valid, 0);
        check("t5_mem_addr_rst", mem_addr, 0);
        req = 4'b1100;
        we  = '0;
        cyc();
        reset = 1'b0;
        #2;
        check("t5_gnt_post", gnt, 4'b0100);
        check("t5_rdv_post", rd_valid, 0);
        req = '0;
        cyc();

        // Idle: no requests, no SRAM activity.
        req   = '0;
        we    = '1;
        wdata = '1;
        w0    = wr_count;
        for (int c = 0; c < 20; c++) begin
            #2;
            check($sformatf("t6_gnt_c%0d", c), gnt, 0);
            check($sformatf("t6_we_c%0d", c), mem_we, 0);
            check($sformatf("t6_addr_c%0d", c), mem_addr, 0);
            cyc();
        end
        check("t6_no_writes", wr_count, w0);
        check("t6_sram_kept", sram[1000], 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
